shift_rows_stream: RTL

- Byte-serial forward AES ShiftRows stage for the encryption datapath.
- Accepts a 16-byte state as a valid/ready byte stream, buffers it, and emits it re-ordered per forward ShiftRows: row r rotated left by r.
- Is the inverse of the block-wide InvShiftRows used on the decrypt side.
- Ping-pong buffering sustains one byte per cycle with no bubbles between blocks.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/shift_rows_stream_sr_bank.sv | 22 ++
 rtl/shift_rows_stream.sv | 92 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-level types and the constant row-rotation index tables
// used by the serial ShiftRows / InvShiftRows stages.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [0:127] aes_state_t;

  // Stream byte k = 4r + c; output k takes buffered byte 4r + ((c + r) mod 4).
  localparam logic [3:0] SR_IDX [0:15] = '{
    4'd0,  4'd1,  4'd2,  4'd3,
    4'd5,  4'd6,  4'd7,  4'd4,
    4'd10, 4'd11, 4'd8,  4'd9,
    4'd15, 4'd12, 4'd13, 4'd14
  };

  // Decrypt-side counterpart: output k takes buffered byte 4r + ((c - r) mod 4).
  localparam logic [3:0] INV_SR_IDX [0:15] = '{
    4'd0,  4'd1,  4'd2,  4'd3,
    4'd7,  4'd4,  4'd5,  4'd6,
    4'd10, 4'd11, 4'd8,  4'd9,
    4'd13, 4'd14, 4'd15, 4'd12
  };

endpackage

// File: rtl/shift_rows_stream_sr_bank.sv
// One 16-byte state buffer: byte write port, combinational indexed read port.
// Contents are data only and are never reset.
module sr_bank
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  logic [3:0] waddr,
  input  aes_byte_t wdata,
  input  logic [3:0] raddr,
  output aes_byte_t rdata
);

  aes_byte_t mem [AES_NB_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/shift_rows_stream.sv
// Byte-serial forward AES ShiftRows: buffers a 16-byte block per bank and
// drains it through the constant rotation table, ping-ponging between banks.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NBANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       err
);

  logic [1:0] full;
  logic       wr_bank, rd_bank;
  logic [3:0] wr_cnt, rd_cnt;
  logic       err_p1;
  aes_byte_t  rd_byte [2];

  logic acc, at_end, frame_err, blk_done, rd_fire;

  assign s_ready   = !full[wr_bank] && !rst;
  assign acc       = s_valid && s_ready;
  assign at_end    = (wr_cnt == 4'd15);
  assign frame_err = acc && (s_last != at_end);
  assign blk_done  = acc && s_last && at_end;

  assign m_valid = full[rd_bank];
  assign m_last  = m_valid && (rd_cnt == 4'd15);
  assign m_data  = m_valid ? rd_byte[rd_bank] : 8'h00;
  assign rd_fire = m_valid && m_ready;
  assign err     = err_p1;

  // A bank is only written while not full and only read while full, so the
  // writer can never land on the bank being drained.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      sr_bank u_bank (
        .clk  (clk),
        .we   (acc && (wr_bank == 1'(b))),
        .waddr(wr_cnt),
        .wdata(s_data),
        .raddr(SR_IDX[rd_cnt]),
        .rdata(rd_byte[b])
      );
    end else begin : g_tie
      assign rd_byte[b] = 8'h00;
    end
  end

  // Control stage: flags, pointers and the registered framing-error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_cnt  <= 4'd0;
      rd_bank <= 1'b0;
      rd_cnt  <= 4'd0;
      err_p1  <= 1'b0;
    end else begin
      err_p1 <= frame_err;
      if (acc) begin
        if (frame_err) begin
          wr_cnt <= 4'd0;
        end else if (blk_done) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= 4'd0;
          wr_bank       <= (NBANK == 2) ? !wr_bank : 1'b0;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
      if (rd_fire) begin
        if (rd_cnt == 4'd15) begin
          full[rd_bank] <= 1'b0;
          rd_cnt        <= 4'd0;
          rd_bank       <= (NBANK == 2) ? !rd_bank : 1'b0;
        end else begin
          rd_cnt <= rd_cnt + 4'd1;
        end
      end
    end
  end

endmodule
